// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter.
//   arb_state_e : arbiter FSM states (IDLE -> ISSUE -> WAIT -> IDLE)
//   arb_owner_e : which requester owns the memory port (instruction or data)
package mem_arbiter_pkg;

    localparam int ARB_STATE_WIDTH = 2;

    typedef enum logic [ARB_STATE_WIDTH-1:0] {
        ARB_STATE_IDLE  = 2'd0,
        ARB_STATE_ISSUE = 2'd1,
        ARB_STATE_WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_OWNER_I = 1'b0,
        ARB_OWNER_D = 1'b1
    } arb_owner_e;

    // Map a one-hot grant vector {d, i} to the owner it selects.
    function automatic arb_owner_e owner_of(input logic [1:0] grant);
        return grant[1] ? ARB_OWNER_D : ARB_OWNER_I;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker, purely combinational.
//   req[0]     : instruction-side request
//   req[1]     : data-side request
//   last_grant : owner granted most recently
//   grant      : one-hot grant (zero when nothing requests)
// A lone request always wins; on a tie the side not granted last time wins.
module arb_rr2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  arb_owner_e last_grant,
    output logic [1:0] grant
);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves it unassigned and a latch is never inferred.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last_grant == ARB_OWNER_D) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single core memory port between instruction fetch (I) and data
// load/store (D). One transaction is outstanding at a time; contention is
// resolved round-robin.
// Ports:
//   clk, rst                 clock and asynchronous active-low reset
//   i_req_* / i_resp_*       fetch request (read only) and response
//   d_req_* / d_resp_*       load/store request and response (store ack data = 0)
//   m_req_* / m_resp_*       downstream memory request and response
// Request ready is combinational in IDLE; m_req_* fields are registered and
// stay stable from acceptance until the memory takes the request.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_req_valid,
    output logic                  i_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic                  i_resp_valid,
    output logic [DATA_WIDTH-1:0] i_resp_data,

    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    input  logic                  d_req_write,
    input  logic [DATA_WIDTH-1:0] d_req_wdata,
    input  logic [STRB_WIDTH-1:0] d_req_strobe,
    output logic                  d_resp_valid,
    output logic [DATA_WIDTH-1:0] d_resp_data,

    output logic                  m_req_valid,
    input  logic                  m_req_ready,
    output logic [ADDR_WIDTH-1:0] m_req_addr,
    output logic                  m_req_write,
    output logic [DATA_WIDTH-1:0] m_req_wdata,
    output logic [STRB_WIDTH-1:0] m_req_strobe,
    input  logic                  m_resp_valid,
    input  logic [DATA_WIDTH-1:0] m_resp_data
);

    arb_state_e state_q, state_d;
    arb_owner_e owner_q;
    arb_owner_e last_grant_q;
    logic [1:0] grant;
    logic       accept;
    logic       route_resp;
    arb_owner_e winner;

    arb_rr2 u_rr (
        .req        ({d_req_valid, i_req_valid}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign winner = owner_of(grant);
    assign accept = (state_q == ARB_STATE_IDLE) && (grant != 2'b00);

    // Ready is gated by rst so nothing is handshaken while reset is held,
    // even though the state register already reads IDLE.
    assign i_req_ready = rst && (state_q == ARB_STATE_IDLE) && grant[0];
    assign d_req_ready = rst && (state_q == ARB_STATE_IDLE) && grant[1];

    assign m_req_valid = (state_q == ARB_STATE_ISSUE);

    // Responses outside WAIT are strays and are dropped.
    assign route_resp   = (state_q == ARB_STATE_WAIT) && m_resp_valid;
    assign i_resp_valid = route_resp && (owner_q == ARB_OWNER_I);
    assign d_resp_valid = route_resp && (owner_q == ARB_OWNER_D);
    assign i_resp_data  = i_resp_valid ? m_resp_data : '0;
    // Store acknowledgements return zero rather than whatever the bus carries.
    assign d_resp_data  = (d_resp_valid && !m_req_write) ? m_resp_data : '0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_STATE_IDLE:  if (accept)       state_d = ARB_STATE_ISSUE;
            ARB_STATE_ISSUE: if (m_req_ready)  state_d = ARB_STATE_WAIT;
            ARB_STATE_WAIT:  if (m_resp_valid) state_d = ARB_STATE_IDLE;
            default:                           state_d = ARB_STATE_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values and simulation ordering cannot change the result.
    // NOTE: every register here is a control or bus-facing flop, so all are
    // reset; leaving m_req_* unreset would expose X on the bus after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARB_STATE_IDLE;
            owner_q      <= ARB_OWNER_I;
            last_grant_q <= ARB_OWNER_D;
            m_req_addr   <= '0;
            m_req_write  <= 1'b0;
            m_req_wdata  <= '0;
            m_req_strobe <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q      <= winner;
                last_grant_q <= winner;
                if (winner == ARB_OWNER_D) begin
                    m_req_addr   <= d_req_addr;
                    m_req_write  <= d_req_write;
                    m_req_wdata  <= d_req_wdata;
                    m_req_strobe <= d_req_write ? d_req_strobe : '0;
                end else begin
                    m_req_addr   <= i_req_addr;
                    m_req_write  <= 1'b0;
                    m_req_wdata  <= '0;
                    m_req_strobe <= '0;
                end
            end
        end
    end

endmodule
